// File: rtl/clock_pkg.sv
// clock_pkg: definitions shared by the clock controller and the text renderer.
//   mode_t     - operating mode encoding (RUN / SET_HR / SET_MIN); 2'd3 is unused
//   *_MAX      - inclusive upper limits of the time fields
//   next_mode  - mode reached on a mode-button press
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  // Any encoding outside the cycle (including the unused one) falls back to RUN.
  function automatic mode_t next_mode(input mode_t cur);
    case (cur)
      MODE_RUN:    return MODE_SET_HR;
      MODE_SET_HR: return MODE_SET_MIN;
      default:     return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD counter, 0..MAX_VAL, wrapping back to 00.
//   clk, reset  - clock and synchronous active-high reset
//   inc         - advance by one this cycle
//   clr         - force to 00 (wins over inc)
//   tens, units - current BCD digits
//   carry       - combinational; high when inc wraps the counter from MAX_VAL
module bcd2_counter #(
  parameter int MAX_VAL = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);

  localparam logic [3:0] MAX_TENS  = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_UNITS = 4'(MAX_VAL % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       at_max;

  always_comb begin
    at_max  = (tens_q == MAX_TENS) && (units_q == MAX_UNITS);
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens_d  = 4'd0;
        units_d = 4'd0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 4'd1;
        units_d = 4'd0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;
  assign carry = inc & ~clr & at_max;

endmodule

// File: rtl/clock_digit_ctrl.sv
// clock_digit_ctrl: 24-hour HH:MM clock with button-driven time setting.
//   clk, reset        - clock and synchronous active-high reset
//   btn_mode, btn_inc - debounced button levels; rising edges are the events
//   frame_tick        - start of vertical blanking; display registers reload here
//   dig0..dig3        - displayed BCD digits H-tens, H-units, M-tens, M-units
//   blank_hr/min      - blink requests for the field being edited
//   mode              - 0 RUN, 1 SET_HR, 2 SET_MIN
module clock_digit_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int BLINK_DIV = CLK_HZ / 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       frame_tick,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       blank_hr,
  output logic       blank_min,
  output logic [1:0] mode
);
  import clock_pkg::*;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  mode_t           state_q, state_d;
  logic            btn_mode_q, btn_inc_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [3:0]      dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d;
  logic            blank_hr_q, blank_hr_d, blank_min_q, blank_min_d;

  logic mode_edge, inc_edge, in_run, sec_tick;
  logic sec_carry, min_carry, hr_carry, min_inc, hr_inc;
  logic [3:0] sec_tens, sec_units, min_tens, min_units, hr_tens, hr_units;

  always_comb begin
    mode_edge = btn_mode & ~btn_mode_q;
    // A simultaneous mode press takes priority; the increment is dropped.
    inc_edge  = btn_inc & ~btn_inc_q & ~mode_edge;
    in_run    = (state_q == MODE_RUN);
    sec_tick  = in_run && (presc_q == PW'(CLK_HZ - 1));
    // Minute carry only reaches hours while running, never while editing minutes.
    min_inc   = sec_carry | ((state_q == MODE_SET_MIN) & inc_edge);
    hr_inc    = (in_run & min_carry) | ((state_q == MODE_SET_HR) & inc_edge);

    state_d = state_q;
    case (state_q)
      MODE_RUN, MODE_SET_HR, MODE_SET_MIN: if (mode_edge) state_d = next_mode(state_q);
      default: state_d = MODE_RUN;
    endcase

    // Held at zero outside RUN so timing restarts cleanly on return.
    presc_d = (!in_run || sec_tick) ? '0 : presc_q + 1'b1;

    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (mode_edge) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    dig0_d      = dig0_q;
    dig1_d      = dig1_q;
    dig2_d      = dig2_q;
    dig3_d      = dig3_q;
    blank_hr_d  = blank_hr_q;
    blank_min_d = blank_min_q;
    if (frame_tick) begin
      dig0_d      = hr_tens;
      dig1_d      = hr_units;
      dig2_d      = min_tens;
      dig3_d      = min_units;
      blank_hr_d  = (state_q == MODE_SET_HR) & phase_q;
      blank_min_d = (state_q == MODE_SET_MIN) & phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MODE_RUN;
      btn_mode_q  <= 1'b0;
      btn_inc_q   <= 1'b0;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      dig0_q      <= 4'd0;
      dig1_q      <= 4'd0;
      dig2_q      <= 4'd0;
      dig3_q      <= 4'd0;
      blank_hr_q  <= 1'b0;
      blank_min_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_mode_q  <= btn_mode;
      btn_inc_q   <= btn_inc;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
      dig2_q      <= dig2_d;
      dig3_q      <= dig3_d;
      blank_hr_q  <= blank_hr_d;
      blank_min_q <= blank_min_d;
    end
  end

  bcd2_counter #(.MAX_VAL(SEC_MAX)) u_sec (
    .clk(clk), .reset(reset), .inc(sec_tick), .clr(~in_run),
    .tens(sec_tens), .units(sec_units), .carry(sec_carry)
  );

  bcd2_counter #(.MAX_VAL(MIN_MAX)) u_min (
    .clk(clk), .reset(reset), .inc(min_inc), .clr(1'b0),
    .tens(min_tens), .units(min_units), .carry(min_carry)
  );

  bcd2_counter #(.MAX_VAL(HOUR_MAX)) u_hr (
    .clk(clk), .reset(reset), .inc(hr_inc), .clr(1'b0),
    .tens(hr_tens), .units(hr_units), .carry(hr_carry)
  );

  // Seconds digits are never displayed and hours have nothing to carry into.
  logic unused_fields;
  assign unused_fields = ^{sec_tens, sec_units, hr_carry};

  assign dig0      = dig0_q;
  assign dig1      = dig1_q;
  assign dig2      = dig2_q;
  assign dig3      = dig3_q;
  assign blank_hr  = blank_hr_q;
  assign blank_min = blank_min_q;
  assign mode      = state_q;

endmodule

// File: tb/tb_clock_digit_ctrl.sv
// Testbench for clock_digit_ctrl: directed scenarios with literal expectations
// plus randomized buttons/frames/resets checked every cycle against a model
// that keeps time as plain integers.
module tb_clock_digit_ctrl;

  localparam int CLK_HZ    = 10;
  localparam int BLINK_DIV = CLK_HZ / 4;

  logic       clk = 1'b0;
  logic       reset, btn_mode, btn_inc, frame_tick;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       blank_hr, blank_min;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  clock_digit_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .frame_tick(frame_tick), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .blank_hr(blank_hr), .blank_min(blank_min), .mode(mode)
  );

  initial forever #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_hh, m_mm, m_ss, m_presc, m_mode, m_bcnt;
  bit m_phase, m_pm, m_pi, m_bh, m_bm;
  int m_dig[4];

  task automatic model_step();
    bit me, ie;
    int t;
    if (reset) begin
      m_hh = 0; m_mm = 0; m_ss = 0; m_presc = 0; m_mode = 0; m_bcnt = 0;
      m_phase = 0; m_pm = 0; m_pi = 0; m_bh = 0; m_bm = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      return;
    end
    me = btn_mode && !m_pm;
    ie = btn_inc && !m_pi && !me;
    if (frame_tick) begin
      m_dig[0] = m_hh / 10; m_dig[1] = m_hh % 10;
      m_dig[2] = m_mm / 10; m_dig[3] = m_mm % 10;
      m_bh = (m_mode == 1) && m_phase;
      m_bm = (m_mode == 2) && m_phase;
    end
    if (m_mode == 0) begin
      if (m_presc == CLK_HZ - 1) begin
        m_presc = 0;
        t = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
        m_hh = t / 3600; m_mm = (t / 60) % 60; m_ss = t % 60;
      end else begin
        m_presc++;
      end
    end else begin
      m_presc = 0;
      m_ss = 0;
      if (ie && m_mode == 1) m_hh = (m_hh + 1) % 24;
      if (ie && m_mode == 2) m_mm = (m_mm + 1) % 60;
    end
    if (me) begin
      m_mode = (m_mode + 1) % 3;
      m_bcnt = 0;
      m_phase = 0;
    end else if (m_bcnt == BLINK_DIV - 1) begin
      m_bcnt = 0;
      m_phase = !m_phase;
    end else begin
      m_bcnt++;
    end
    m_pm = btn_mode;
    m_pi = btn_inc;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checks++;
      if (dig0 !== 4'(m_dig[0]) || dig1 !== 4'(m_dig[1]) || dig2 !== 4'(m_dig[2]) ||
          dig3 !== 4'(m_dig[3]) || blank_hr !== m_bh || blank_min !== m_bm ||
          mode !== 2'(m_mode)) begin
        errors++;
        $display("FAIL model_cycle t=%0t got dig=%0d%0d:%0d%0d bh=%0b bm=%0b mode=%0d required dig=%0d%0d:%0d%0d bh=%0b bm=%0b mode=%0d",
                 $time, dig0, dig1, dig2, dig3, blank_hr, blank_min, mode,
                 m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_bh, m_bm, m_mode);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1; cycle();
    btn_mode = 1'b0; cycle();
  endtask

  task automatic pulse_inc();
    btn_inc = 1'b1; cycle();
    btn_inc = 1'b0; cycle();
  endtask

  task automatic frame();
    frame_tick = 1'b1; cycle();
    frame_tick = 1'b0;
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic check_dig(input string name, input int e0, input int e1, input int e2, input int e3);
    check_val(name, int'(dig0) * 1000 + int'(dig1) * 100 + int'(dig2) * 10 + int'(dig3),
              e0 * 1000 + e1 * 100 + e2 * 10 + e3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; frame_tick = 1'b0;
    cycle(); cycle();
    check_dig("reset_dig", 0, 0, 0, 0);
    check_val("reset_mode", int'(mode), 0);
    check_val("reset_blank", int'({blank_hr, blank_min}), 0);
    chk_en = 1'b1;
    reset = 1'b0;

    // 600 cycles = 60 seconds at CLK_HZ=10
    repeat (600) cycle();
    frame();
    check_dig("one_minute", 0, 0, 0, 1);
    check_val("one_minute_mode", int'(mode), 0);

    // enter SET_HR: field visible first, blanked one blink phase later
    pulse_mode();
    check_val("enter_set_hr", int'(mode), 1);
    frame();
    check_val("blink_restart_visible", int'(blank_hr), 0);
    frame();
    check_val("blink_phase_blank", int'(blank_hr), 1);
    check_val("blink_min_off", int'(blank_min), 0);

    repeat (25) pulse_inc();
    frame();
    check_dig("hours_25_incs", 0, 1, 0, 1);
    check_val("setting_mode", int'(mode), 1);
    pulse_mode();
    check_val("enter_set_min", int'(mode), 2);

    repeat (58) pulse_inc();
    frame();
    check_dig("min_at_59", 0, 1, 5, 9);
    pulse_inc();
    frame();
    check_dig("min_wrap_no_carry", 0, 1, 0, 0);

    // preload 23:59 then run to 23:59:59 and over midnight
    pulse_mode();
    pulse_mode();
    repeat (22) pulse_inc();
    pulse_mode();
    repeat (59) pulse_inc();
    pulse_mode();
    check_val("back_to_run", int'(mode), 0);
    repeat (590) cycle();
    frame();
    check_dig("at_235959", 2, 3, 5, 9);
    repeat (10) cycle();
    frame();
    check_dig("midnight_wrap", 0, 0, 0, 0);

    // simultaneous mode+inc in RUN
    btn_mode = 1'b1; btn_inc = 1'b1; cycle();
    btn_mode = 1'b0; btn_inc = 1'b0; cycle();
    check_val("simul_mode", int'(mode), 1);
    frame();
    check_dig("simul_hours_kept", 0, 0, 0, 0);

    // working change is invisible until frame_tick
    pulse_inc();
    repeat (5) cycle();
    check_dig("no_frame_hold", 0, 0, 0, 0);
    frame();
    check_dig("frame_update", 0, 1, 0, 0);

    // reset abandons an edit in SET_MIN
    pulse_mode();
    pulse_inc();
    frame();
    check_dig("pre_reset", 0, 1, 0, 1);
    reset = 1'b1; cycle();
    check_dig("reset_in_set_dig", 0, 0, 0, 0);
    check_val("reset_in_set_mode", int'(mode), 0);
    check_val("reset_in_set_blank", int'({blank_hr, blank_min}), 0);
    reset = 1'b0;

    // randomized traffic, compared every cycle
    for (int i = 0; i < 3000; i++) begin
      btn_mode   = ($urandom_range(0, 19) == 0);
      btn_inc    = ($urandom_range(0, 3) == 0);
      frame_tick = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; frame_tick = 1'b0;
    cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
